// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage registers: control-bit layout and default widths.
package pipe_pkg;

    localparam int CTRL_W        = 6;
    localparam int CTRL_BRANCH   = 5;
    localparam int CTRL_JAL      = 4;
    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_WEN      = 0;

    localparam int DSIZE_DEF = 16;
    localparam int ASIZE_DEF = 4;
    localparam int ISIZE_DEF = 16;
    localparam int OPW_DEF   = 4;
    localparam int CNTW_DEF  = 16;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: the instruction in EXE is a load whose
// destination is read by the instruction now in decode.
module load_use_detect #(
    parameter int ASIZE = 4,
    parameter bit EN    = 1'b1
) (
    input  logic             i_valid,
    input  logic [ASIZE-1:0] i_rs,
    input  logic [ASIZE-1:0] i_rt,
    input  logic             i_uses_rt,
    input  logic             i_ex_valid,
    input  logic             i_ex_memread,
    input  logic [ASIZE-1:0] i_ex_waddr,
    output logic             o_haz
);

    generate
        if (EN) begin : g_det
            logic w_rs_hit;
            logic w_rt_hit;
            assign w_rs_hit = (i_ex_waddr == i_rs);
            assign w_rt_hit = i_uses_rt & (i_ex_waddr == i_rt);
            // r0 is hardwired, so a load to it never creates a dependency
            assign o_haz = i_valid & i_ex_valid & i_ex_memread &
                           (i_ex_waddr != '0) & (w_rs_hit | w_rt_hit);
        end else begin : g_off
            assign o_haz = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/id_exe_pipe.sv
// ID/EXE stage register with valid bit, stall/flush, load-use bubble insertion
// and a saturating bubble counter.
module id_exe_pipe
    import pipe_pkg::*;
#(
    parameter int DSIZE  = DSIZE_DEF,
    parameter int ASIZE  = ASIZE_DEF,
    parameter int ISIZE  = ISIZE_DEF,
    parameter int OPW    = OPW_DEF,
    parameter int CNTW   = CNTW_DEF,
    parameter bit HAZ_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic [ASIZE-1:0]  rs_in,
    input  logic [ASIZE-1:0]  rt_in,
    input  logic [ASIZE-1:0]  rd_in,
    input  logic [ASIZE-1:0]  waddr_in,
    input  logic              uses_rt_in,
    input  logic [DSIZE-1:0]  rdata1_in,
    input  logic [DSIZE-1:0]  rdata2_in,
    input  logic [DSIZE-1:0]  imm_in,
    input  logic [OPW-1:0]    opcode_in,
    input  logic              alusrc_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [ISIZE-1:0]  pc_in,
    output logic              valid_out,
    output logic [ASIZE-1:0]  rs_out,
    output logic [ASIZE-1:0]  rt_out,
    output logic [ASIZE-1:0]  rd_out,
    output logic [ASIZE-1:0]  waddr_out,
    output logic [DSIZE-1:0]  rdata1_out,
    output logic [DSIZE-1:0]  rdata2_out,
    output logic [DSIZE-1:0]  imm_out,
    output logic [OPW-1:0]    opcode_out,
    output logic              alusrc_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [ISIZE-1:0]  pc_out,
    output logic              hazard_stall,
    output logic [CNTW-1:0]   bubble_cnt
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic w_haz;
    logic w_bubble;
    logic w_load;

    load_use_detect #(.ASIZE(ASIZE), .EN(HAZ_EN)) u_lud (
        .i_valid      (valid_in),
        .i_rs         (rs_in),
        .i_rt         (rt_in),
        .i_uses_rt    (uses_rt_in),
        .i_ex_valid   (valid_out),
        .i_ex_memread (ctrl_out[CTRL_MEMREAD]),
        .i_ex_waddr   (waddr_out),
        .o_haz        (w_haz)
    );

    assign hazard_stall = w_haz & ~flush_in & ~stall_in;
    assign w_bubble     = flush_in | hazard_stall;
    // Flush still loads the data fields; only stall and a hazard bubble hold them
    assign w_load       = flush_in | (~stall_in & ~hazard_stall);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out  <= 1'b0;
            rs_out     <= '0;
            rt_out     <= '0;
            rd_out     <= '0;
            waddr_out  <= '0;
            rdata1_out <= '0;
            rdata2_out <= '0;
            imm_out    <= '0;
            opcode_out <= '0;
            alusrc_out <= 1'b0;
            ctrl_out   <= '0;
            pc_out     <= '0;
            bubble_cnt <= '0;
        end else begin
            if (w_load) begin
                rs_out     <= rs_in;
                rt_out     <= rt_in;
                rd_out     <= rd_in;
                waddr_out  <= waddr_in;
                rdata1_out <= rdata1_in;
                rdata2_out <= rdata2_in;
                imm_out    <= imm_in;
                opcode_out <= opcode_in;
                alusrc_out <= alusrc_in;
                pc_out     <= pc_in;
            end
            if (w_bubble) begin
                valid_out <= 1'b0;
                ctrl_out  <= '0;
            end else if (w_load) begin
                valid_out <= valid_in;
                ctrl_out  <= valid_in ? ctrl_in : '0;
            end
            if (w_bubble && bubble_cnt != CNT_MAX)
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_exe_pipe.sv
// Self-checking bench for id_exe_pipe: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the stage.
module tb_id_exe_pipe;

    logic        clk = 1'b0;
    logic        rst, valid_in, stall_in, flush_in, uses_rt_in, alusrc_in;
    logic [3:0]  rs_in, rt_in, rd_in, waddr_in, opcode_in;
    logic [15:0] rdata1_in, rdata2_in, imm_in, pc_in;
    logic [5:0]  ctrl_in;

    logic        valid_out, alusrc_out, hazard_stall, hazard_stall2, valid_out2;
    logic [3:0]  rs_out, rt_out, rd_out, waddr_out, opcode_out;
    logic [15:0] rdata1_out, rdata2_out, imm_out, pc_out, bubble_cnt;
    logic [5:0]  ctrl_out;
    logic [1:0]  bubble_cnt2;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    id_exe_pipe dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .stall_in(stall_in), .flush_in(flush_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .waddr_in(waddr_in), .uses_rt_in(uses_rt_in),
        .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .imm_in(imm_in), .opcode_in(opcode_in),
        .alusrc_in(alusrc_in), .ctrl_in(ctrl_in), .pc_in(pc_in),
        .valid_out(valid_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .waddr_out(waddr_out), .rdata1_out(rdata1_out), .rdata2_out(rdata2_out), .imm_out(imm_out),
        .opcode_out(opcode_out), .alusrc_out(alusrc_out), .ctrl_out(ctrl_out), .pc_out(pc_out),
        .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
    );

    // Narrow-counter copy for saturation; its other outputs are not of interest
    logic [3:0]  u_rs, u_rt, u_rd, u_wa, u_op;
    logic [15:0] u_d1, u_d2, u_im, u_pc;
    logic [5:0]  u_ct;
    logic        u_as;
    id_exe_pipe #(.CNTW(2)) dut_sat (
        .clk(clk), .rst(rst), .valid_in(valid_in), .stall_in(stall_in), .flush_in(flush_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .waddr_in(waddr_in), .uses_rt_in(uses_rt_in),
        .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .imm_in(imm_in), .opcode_in(opcode_in),
        .alusrc_in(alusrc_in), .ctrl_in(ctrl_in), .pc_in(pc_in),
        .valid_out(valid_out2), .rs_out(u_rs), .rt_out(u_rt), .rd_out(u_rd),
        .waddr_out(u_wa), .rdata1_out(u_d1), .rdata2_out(u_d2), .imm_out(u_im),
        .opcode_out(u_op), .alusrc_out(u_as), .ctrl_out(u_ct), .pc_out(u_pc),
        .hazard_stall(hazard_stall2), .bubble_cnt(bubble_cnt2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // EXE-stage contents as an instruction record plus the two bubble tallies
    typedef struct packed {
        logic        valid;
        logic [3:0]  rs, rt, rd, waddr, opcode;
        logic [15:0] rdata1, rdata2, imm, pc;
        logic        alusrc;
        logic [5:0]  ctrl;
    } instr_t;

    instr_t m_ex;
    int     m_cnt, m_cnt2;

    function automatic bit m_load_use();
        bit dep;
        dep = (m_ex.waddr == rs_in) || (uses_rt_in && m_ex.waddr == rt_in);
        return valid_in && m_ex.valid && m_ex.ctrl[3] && m_ex.waddr != 0 && dep;
    endfunction

    function automatic bit m_hstall();
        return m_load_use() && !flush_in && !stall_in;
    endfunction

    function automatic instr_t incoming();
        instr_t t;
        t.valid = valid_in; t.rs = rs_in; t.rt = rt_in; t.rd = rd_in; t.waddr = waddr_in;
        t.opcode = opcode_in; t.rdata1 = rdata1_in; t.rdata2 = rdata2_in; t.imm = imm_in;
        t.pc = pc_in; t.alusrc = alusrc_in; t.ctrl = valid_in ? ctrl_in : 6'd0;
        return t;
    endfunction

    always @(posedge clk) begin
        instr_t nx;
        bit     bub;
        nx  = m_ex;
        bub = 1'b0;
        if (flush_in) begin
            nx = incoming(); nx.valid = 1'b0; nx.ctrl = 6'd0; bub = 1'b1;
        end else if (stall_in) begin
            nx = m_ex;
        end else if (m_load_use()) begin
            nx.valid = 1'b0; nx.ctrl = 6'd0; bub = 1'b1;
        end else begin
            nx = incoming();
        end
        if (rst) begin
            m_ex   <= '0;
            m_cnt  <= 0;
            m_cnt2 <= 0;
        end else begin
            m_ex   <= nx;
            m_cnt  <= (bub && m_cnt  < 65535) ? m_cnt  + 1 : m_cnt;
            m_cnt2 <= (bub && m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m.valid",  valid_out,    m_ex.valid);
            chk("m.ctrl",   ctrl_out,     m_ex.ctrl);
            chk("m.regs",   {rs_out, rt_out, rd_out, waddr_out, opcode_out},
                            {m_ex.rs, m_ex.rt, m_ex.rd, m_ex.waddr, m_ex.opcode});
            chk("m.data",   {rdata1_out, rdata2_out, imm_out}, {m_ex.rdata1, m_ex.rdata2, m_ex.imm});
            chk("m.pc",     {pc_out, 15'd0, alusrc_out}, {m_ex.pc, 15'd0, m_ex.alusrc});
            chk("m.hstall", hazard_stall, m_hstall());
            chk("m.cnt",    bubble_cnt,   m_cnt);
            chk("m.cnt2",   bubble_cnt2,  m_cnt2);
            if (!valid_out) chk("inv.ctrl0", ctrl_out, 6'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                             input logic [3:0] wa, input logic [5:0] ct, input logic [15:0] pc);
        valid_in = v; rs_in = rs; rt_in = rt; rd_in = wa; waddr_in = wa; ctrl_in = ct; pc_in = pc;
        uses_rt_in = 1'b0; opcode_in = 4'h2; alusrc_in = 1'b0;
        rdata1_in = 16'h0A00 + pc; rdata2_in = 16'h0B00 + pc; imm_in = 16'h0C00 + pc;
    endtask

    initial begin
        // reset with every input nonzero
        rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
        set_instr(1'b1, 4'hF, 4'hE, 4'hD, 6'h3F, 16'hFFFF);
        uses_rt_in = 1'b1; alusrc_in = 1'b1;
        step(); step();
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst.valid", valid_out, 1'b0);
        chk("rst.pc",    pc_out, 16'h0);
        chk("rst.cnt",   bubble_cnt, 16'h0);
        chk("rst.d1",    rdata1_out, 16'h0);

        // normal flow
        rst = 1'b0;
        step();
        set_instr(1'b1, 4'h1, 4'h2, 4'h5, 6'b000001, 16'h0010);
        rdata1_in = 16'h1234;
        step();
        @(negedge clk);
        chk("nrm.valid", valid_out, 1'b1);
        chk("nrm.d1",    rdata1_out, 16'h1234);
        chk("nrm.pc",    pc_out, 16'h0010);
        chk("nrm.ctrl",  ctrl_out, 6'b000001);

        // load-use: load to r3 then add reading r3
        set_instr(1'b1, 4'h1, 4'h2, 4'h3, 6'b001011, 16'h0014);
        step();
        set_instr(1'b1, 4'h3, 4'h2, 4'h4, 6'b000001, 16'h0018);
        @(negedge clk);
        chk("lu.hstall", hazard_stall, 1'b1);
        step();
        @(negedge clk);
        chk("lu.bvalid", valid_out, 1'b0);
        chk("lu.bctrl",  ctrl_out, 6'd0);
        chk("lu.cnt",    bubble_cnt, 16'd1);
        chk("lu.hold",   waddr_out, 4'h3);
        chk("lu.clear",  hazard_stall, 1'b0);
        step();
        @(negedge clk);
        chk("lu.avalid", valid_out, 1'b1);
        chk("lu.apc",    pc_out, 16'h0018);

        // load to r0 followed by read of r0: no stall
        set_instr(1'b1, 4'h1, 4'h2, 4'h0, 6'b001011, 16'h0020);
        step();
        set_instr(1'b1, 4'h0, 4'h0, 4'h4, 6'b000001, 16'h0024);
        uses_rt_in = 1'b1;
        @(negedge clk);
        chk("r0.hstall", hazard_stall, 1'b0);
        step();

        // flush coincident with hazard
        set_instr(1'b1, 4'h1, 4'h2, 4'h3, 6'b001011, 16'h0030);
        step();
        set_instr(1'b1, 4'h3, 4'h2, 4'h4, 6'b000001, 16'h0034);
        flush_in = 1'b1;
        @(negedge clk);
        chk("fl.hstall", hazard_stall, 1'b0);
        step();
        flush_in = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        chk("fl.valid", valid_out, 1'b0);
        chk("fl.cnt",   bubble_cnt, 16'd2);

        // stall hold for 3 cycles, then reset during a stall
        set_instr(1'b1, 4'h1, 4'h2, 4'h3, 6'b001011, 16'h0040);
        step();
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(1'b1, 4'h3, 4'(i), 4'h7, 6'b000011, 16'(16'h0100 + i));
            @(negedge clk);
            chk("st.hstall", hazard_stall, 1'b0);
            step();
            @(negedge clk);
            chk("st.pc",  pc_out, 16'h0040);
            chk("st.cnt", bubble_cnt, 16'd2);
        end
        rst = 1'b1;
        step();
        rst = 1'b0; stall_in = 1'b0;
        @(negedge clk);
        chk("strst.pc",  pc_out, 16'h0);
        chk("strst.cnt", bubble_cnt, 16'h0);

        // five flushes: narrow counter saturates at 3
        flush_in = 1'b1;
        for (int i = 0; i < 5; i++) step();
        flush_in = 1'b0;
        @(negedge clk);
        chk("sat.cnt2", bubble_cnt2, 2'd3);
        chk("sat.cnt",  bubble_cnt, 16'd5);
        step();
        @(negedge clk);
        chk("sat.hold", bubble_cnt2, 2'd3);

        // randomized traffic; narrow address range makes hazards frequent
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 99) < 2);
            flush_in   = ($urandom_range(0, 99) < 10);
            stall_in   = ($urandom_range(0, 99) < 12);
            valid_in   = ($urandom_range(0, 99) < 85);
            rs_in      = 4'($urandom_range(0, 3));
            rt_in      = 4'($urandom_range(0, 3));
            rd_in      = 4'($urandom);
            waddr_in   = 4'($urandom_range(0, 3));
            uses_rt_in = 1'($urandom);
            opcode_in  = 4'($urandom);
            alusrc_in  = 1'($urandom);
            ctrl_in    = 6'($urandom) | (($urandom_range(0, 1) == 1) ? 6'b001000 : 6'b0);
            rdata1_in  = 16'($urandom);
            rdata2_in  = 16'($urandom);
            imm_in     = 16'($urandom);
            pc_in      = 16'($urandom);
            step();
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
